// File: rtl/partial_sum_accumulator.sv
// rtl/partial_sum_accumulator.sv - frame accumulator for adder-tree partial sums with a one-entry result register
// Optional clamp arithmetic: define PSUM_ACC_SATURATE_EN.
module partial_sum_accumulator #(
  parameter int IN_WIDTH  = 11,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  sum_i,
  input  logic                 start_i,
  input  logic                 final_flag_i,
  input  logic                 sigma_tag_i,
  input  logic                 clear_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 acc_tag_o,
  output logic [CNT_WIDTH-1:0] acc_beats_o,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic                 busy_o,
  output logic                 tag_err_o,
  output logic                 drop_o,
  output logic                 sat_o
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t state, state_nxt;

  logic signed [ACC_WIDTH-1:0] acc, acc_nxt, acc_sum, sum_ext;
  logic                        tag, tag_nxt;
  logic [CNT_WIDTH-1:0]        cnt, cnt_nxt;
  logic                        beat, complete;

  assign sum_ext  = ACC_WIDTH'($signed(sum_i));
  assign beat     = start_i && !clear_i;
  assign complete = beat && final_flag_i;

`ifdef PSUM_ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] add_wide;
  logic               add_ovf;
  logic               sat_frame, sat_nxt;

  // One guard bit: overflow shows up as the two top bits disagreeing.
  assign add_wide = {acc[ACC_WIDTH-1], acc} + {sum_ext[ACC_WIDTH-1], sum_ext};
  assign add_ovf  = add_wide[ACC_WIDTH] ^ add_wide[ACC_WIDTH-1];
  assign acc_sum  = add_ovf ? (add_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                            : add_wide[ACC_WIDTH-1:0];
`else
  assign acc_sum  = acc + sum_ext;
  assign sat_o    = 1'b0;
`endif

  // Values the frame registers take on a beat; also what a completing frame publishes.
  always_comb begin
    acc_nxt = sum_ext;
    tag_nxt = sigma_tag_i;
    cnt_nxt = CNT_WIDTH'(1);
`ifdef PSUM_ACC_SATURATE_EN
    sat_nxt = 1'b0;
`endif
    if (state == ACC) begin
      acc_nxt = acc_sum;
      tag_nxt = tag;
      cnt_nxt = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);
`ifdef PSUM_ACC_SATURATE_EN
      sat_nxt = sat_frame | add_ovf;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (beat && !final_flag_i) state_nxt = ACC;
      ACC:  if (clear_i || complete)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == ACC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      tag       <= 1'b0;
      cnt       <= '0;
      tag_err_o <= 1'b0;
`ifdef PSUM_ACC_SATURATE_EN
      sat_frame <= 1'b0;
`endif
    end else if (clear_i) begin
      acc       <= '0;
      tag       <= 1'b0;
      cnt       <= '0;
      tag_err_o <= 1'b0;
`ifdef PSUM_ACC_SATURATE_EN
      sat_frame <= 1'b0;
`endif
    end else if (beat) begin
      acc <= acc_nxt;
      tag <= tag_nxt;
      cnt <= cnt_nxt;
`ifdef PSUM_ACC_SATURATE_EN
      sat_frame <= sat_nxt;
`endif
      if (state == ACC && sigma_tag_i != tag) tag_err_o <= 1'b1;
    end
  end

  // Result register: a completion while the register is stuck full is dropped, old result kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_o       <= '0;
      acc_tag_o   <= 1'b0;
      acc_beats_o <= '0;
      acc_valid_o <= 1'b0;
      drop_o      <= 1'b0;
`ifdef PSUM_ACC_SATURATE_EN
      sat_o       <= 1'b0;
`endif
    end else begin
      drop_o <= 1'b0;
      if (complete) begin
        if (!acc_valid_o || acc_ready_i) begin
          acc_o       <= acc_nxt;
          acc_tag_o   <= tag_nxt;
          acc_beats_o <= cnt_nxt;
          acc_valid_o <= 1'b1;
`ifdef PSUM_ACC_SATURATE_EN
          sat_o       <= sat_nxt;
`endif
        end else begin
          drop_o <= 1'b1;
        end
      end else if (acc_valid_o && acc_ready_i) begin
        acc_valid_o <= 1'b0;
      end
    end
  end

endmodule
